pc_stack_unit: RTL

- Next-PC stage directly upstream of the fetch/decode block; drives the word-indexed PC that indexes instruction memory.
- Consumes the decoder's PC-source select, call/ret and branch-outcome signals.
- Owns the PC register and a hardware return-address stack (RAS) for CALL/RET.
- Reports stack depth and status.

---
 rtl/pc_stack_unit.sv | 134 +++++++++++++
 1 files changed

// File: rtl/pc_stack_unit.sv
// Next-PC stage: owns the PC register and a return-address stack for CALL/RET.
// Optional macro PC_FLUSH_EN adds flush/flush_target, which override stall and clear the stack.
module pc_stack_unit #(
  parameter int PC_W     = 32,
  parameter int DEPTH    = 8,
  parameter int RESET_PC = 0
) (
  input  logic                     clk,
  input  logic                     reset,
`ifdef PC_FLUSH_EN
  input  logic                     flush,
  input  logic [PC_W-1:0]          flush_target,
`endif
  input  logic                     stall,
  input  logic [1:0]               pc_src,
  input  logic                     call,
  input  logic                     ret,
  input  logic                     branch_taken,
  input  logic [15:0]              branch_offset,
  input  logic [PC_W-1:0]          jump_target,
  output logic [PC_W-1:0]          pc,
  output logic [$clog2(DEPTH):0]   stack_depth,
  output logic                     stack_empty,
  output logic                     stack_full,
  output logic                     stack_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = AW + 1;

  typedef enum logic [2:0] {
    OP_SEQ,
    OP_BR_T,
    OP_JUMP,
    OP_CALL,
    OP_RET
  } op_t;

  op_t             op;
  logic [PC_W-1:0] ras [DEPTH];
  logic [PC_W-1:0] pc_inc;
  logic [PC_W-1:0] br_target;
  logic [PC_W-1:0] pc_nxt;
  logic [DW-1:0]   depth_nxt;
  logic            err_nxt;
  logic            push_en;
  logic [AW-1:0]   top_idx;
  logic [AW-1:0]   wr_idx;

  assign stack_empty = (stack_depth == '0);
  assign stack_full  = (stack_depth == DW'(DEPTH));

  assign pc_inc    = pc + PC_W'(1);
  assign br_target = pc + PC_W'($signed(branch_offset));
  assign top_idx   = AW'(stack_depth - DW'(1));
  assign wr_idx    = stack_depth[AW-1:0];

  // Instruction class; call/ret only matter for the jump-class select, and ret beats call.
  always_comb begin
    op = OP_SEQ;
    case (pc_src)
      2'b01: begin
        if (ret)       op = OP_RET;
        else if (call) op = OP_CALL;
        else           op = OP_JUMP;
      end
      2'b00:   op = branch_taken ? OP_BR_T : OP_SEQ;
      default: op = OP_SEQ;
    endcase
  end

  always_comb begin
    pc_nxt    = pc_inc;
    depth_nxt = stack_depth;
    err_nxt   = stack_err;
    push_en   = 1'b0;
    case (op)
      OP_RET: begin
        if (!stack_empty) begin
          pc_nxt    = ras[top_idx];
          depth_nxt = stack_depth - DW'(1);
        end else begin
          err_nxt = 1'b1;
        end
      end
      OP_CALL: begin
        pc_nxt = jump_target;
        if (!stack_full) begin
          push_en   = 1'b1;
          depth_nxt = stack_depth + DW'(1);
        end else begin
          err_nxt = 1'b1;
        end
      end
      OP_JUMP: pc_nxt = jump_target;
      OP_BR_T: pc_nxt = br_target;
      default: pc_nxt = pc_inc;
    endcase

    if (stall) begin
      pc_nxt    = pc;
      depth_nxt = stack_depth;
      err_nxt   = stack_err;
      push_en   = 1'b0;
    end

`ifdef PC_FLUSH_EN
    if (flush) begin
      pc_nxt    = flush_target;
      depth_nxt = '0;
      err_nxt   = stack_err;
      push_en   = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= PC_W'(RESET_PC);
      stack_depth <= '0;
      stack_err   <= 1'b0;
    end else begin
      pc          <= pc_nxt;
      stack_depth <= depth_nxt;
      stack_err   <= err_nxt;
    end
  end

  // Stack storage needs no reset: entries above stack_depth are never read.
  always_ff @(posedge clk) begin
    if (push_en) ras[wr_idx] <= pc_inc;
  end

endmodule
